// File: rtl/adiantamento_pkg.sv
// Shared types for the forwarding unit: selector encoding, pipeline slot record, source test.
// The slot record stores a LARGURA_REG_PKG-bit index; the top-level LARGURA_REG must equal it.
package adiantamento_pkg;

  localparam int unsigned LARGURA_REG_PKG = 5;

  typedef enum logic [1:0] {
    SEL_REGISTRADOR = 2'b00,
    SEL_EX_MEM      = 2'b01,
    SEL_MEM_WB      = 2'b10
  } seletor_t;

  localparam logic [LARGURA_REG_PKG-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                       valido;
    logic [LARGURA_REG_PKG-1:0] rd;
    logic                       escreve;
    logic                       le_mem;
  } slot_t;

  // A slot can only forward if it really writes a non-zero register.
  function automatic logic eh_fonte(input slot_t s);
    return s.valido && s.escreve && (s.rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/comparador_adiantamento.sv
// Per-operand forwarding select: newest producer (EX) wins over MEM, else register file.
module comparador_adiantamento
  import adiantamento_pkg::*;
(
  input  logic [LARGURA_REG_PKG-1:0] indice,
  input  slot_t                      slot_ex,
  input  slot_t                      slot_mem,
  output seletor_t                   seletor
);

  always_comb begin
    seletor = SEL_REGISTRADOR;
    if (eh_fonte(slot_ex) && (slot_ex.rd == indice)) begin
      seletor = SEL_EX_MEM;
    end else if (eh_fonte(slot_mem) && (slot_mem.rd == indice)) begin
      seletor = SEL_MEM_WB;
    end
  end

endmodule

// File: rtl/unidade_adiantamento.sv
// Forwarding and load-use hazard unit: tracks EX/MEM destinations, registers ALU operand selects.
// Optional stall counter enabled by defining CONTADOR_BOLHAS_EN.
module unidade_adiantamento
  import adiantamento_pkg::*;
#(
  parameter int unsigned LARGURA_REG      = 5,
  parameter int unsigned LARGURA_CONTADOR = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        habilita,
  input  logic                        flush,
  input  logic                        id_valido,
  input  logic [LARGURA_REG-1:0]      id_rs,
  input  logic [LARGURA_REG-1:0]      id_rt,
  input  logic [LARGURA_REG-1:0]      id_rd,
  input  logic                        id_escreve_reg,
  input  logic                        id_le_memoria,
  output logic [1:0]                  seletor_a,
  output logic [1:0]                  seletor_b,
  output logic                        bolha,
  output logic [LARGURA_CONTADOR-1:0] contador_bolhas
);

  slot_t    slot_ex, slot_mem, slot_id;
  seletor_t sel_a_q, sel_b_q, sel_a_d, sel_b_d;
  logic     hazard;

  assign slot_id = '{valido:  id_valido,
                     rd:      id_rd,
                     escreve: id_escreve_reg,
                     le_mem:  id_le_memoria};

  comparador_adiantamento u_comp_a (
    .indice   (id_rs),
    .slot_ex  (slot_ex),
    .slot_mem (slot_mem),
    .seletor  (sel_a_d)
  );

  comparador_adiantamento u_comp_b (
    .indice   (id_rt),
    .slot_ex  (slot_ex),
    .slot_mem (slot_mem),
    .seletor  (sel_b_d)
  );

  always_comb begin
    hazard = id_valido && slot_ex.le_mem && eh_fonte(slot_ex) &&
             ((id_rs == slot_ex.rd) || (id_rt == slot_ex.rd));
  end

  assign bolha = hazard && !flush;

  // A stalled or flushed ID instruction is replaced in EX by an invalid record with 00 selects.
  always_ff @(posedge clock) begin
    if (!reset) begin
      slot_ex  <= '0;
      slot_mem <= '0;
      sel_a_q  <= SEL_REGISTRADOR;
      sel_b_q  <= SEL_REGISTRADOR;
    end else if (habilita) begin
      slot_mem <= slot_ex;
      if (flush || bolha) begin
        slot_ex <= '0;
        sel_a_q <= SEL_REGISTRADOR;
        sel_b_q <= SEL_REGISTRADOR;
      end else begin
        slot_ex <= slot_id;
        sel_a_q <= sel_a_d;
        sel_b_q <= sel_b_d;
      end
    end
  end

  assign seletor_a = sel_a_q;
  assign seletor_b = sel_b_q;

`ifdef CONTADOR_BOLHAS_EN
  logic [LARGURA_CONTADOR-1:0] contador_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      contador_q <= '0;
    end else if (habilita && bolha) begin
      contador_q <= contador_q + LARGURA_CONTADOR'(1);
    end
  end

  assign contador_bolhas = contador_q;
`else
  assign contador_bolhas = '0;
`endif

endmodule

// File: doc/unidade_adiantamento.md
Name: unidade_adiantamento

Overview:
- Forwarding and load-use hazard unit for the 32-bit pipelined datapath.
- Tracks the destination registers of the instructions in the EX and MEM slots.
- Drives registered 2-bit selectors for the two 3-input operand muxes feeding the ALU: 00 = register-file value, 01 = EX/MEM result, 10 = MEM/WB result.
- Stalls IF/ID for one cycle on a load-use dependency by inserting a bubble into EX.

Parameters:
- LARGURA_REG, 5, register-index width.
- LARGURA_CONTADOR, 32, width of the bubble counter.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low; sampled on the rising edge of clock.
- habilita  in  1  pipeline advance; 0 = every register holds.
- flush  in  1  squash the ID instruction (taken branch/jump).
- id_valido  in  1  ID slot holds a real instruction.
- id_rs  in  LARGURA_REG  first source register of the ID instruction.
- id_rt  in  LARGURA_REG  second source register of the ID instruction.
- id_rd  in  LARGURA_REG  resolved destination register of the ID instruction.
- id_escreve_reg  in  1  ID instruction writes the register file.
- id_le_memoria  in  1  ID instruction is a load.
- seletor_a  out  2  mux select for operand A of the instruction now in EX.
- seletor_b  out  2  mux select for operand B of the instruction now in EX.
- bolha  out  1  hold PC and IF/ID this cycle.
- contador_bolhas  out  LARGURA_CONTADOR  stall-cycle count.

Behaviour:
- State is two slot records, EX and MEM. Each record holds: valido, rd, escreve, le_mem.
- A slot is a forwarding source only when valido=1, escreve=1 and rd!=0.
- Reset (reset=0 at an edge): both valido bits cleared, seletor_a=seletor_b=00, contador_bolhas=0. Reset mid-stall drops the stall; bolha reads 0 from the next cycle.
- Hazard (combinational) = id_valido & EX.valido & EX.le_mem & EX.escreve & EX.rd!=0 & (id_rs==EX.rd | id_rt==EX.rd).
- bolha = hazard & ~flush. Depends only on registered state and current inputs, so it is 0 after reset.
- Edge with habilita=1:
  - MEM <= EX.
  - EX <= ID record, or a bubble (valido=0, seletores 00) if flush=1 or bolha=1.
- Selector for each operand (computed at the same edge as the ID->EX load, from the pre-edge records):
  - 01 if the operand index matches the EX record, i.e. the instruction that becomes MEM.
  - Otherwise 10 if it matches the MEM record, i.e. the instruction that becomes WB.
  - Otherwise 00.
  - The newer producer (01) always wins.
  - Index 0 always yields 00.
- Latency: selectors are valid during the whole cycle the instruction occupies EX.
- Edge with habilita=0: all records, selectors and the counter hold. bolha stays combinational.
- Load-use sequence:
  - Cycle t: bolha=1; load moves to MEM; EX gets a bubble.
  - Cycle t+1: hazard is false.
  - The dependent instruction enters EX at t+2 with selector 10.
  - Exactly one bubble per load-use pair; back-to-back loads are handled identically.
- flush has priority over bolha. flush never touches the MEM record, so older instructions complete.
- Instructions older than WB are never forwarded; the register file supplies them.

Optional Feature:
- Macro: CONTADOR_BOLHAS_EN.
- Defined: contador_bolhas increments by 1 on each edge with habilita=1 and bolha=1, and wraps modulo 2^LARGURA_CONTADOR.
- Undefined: port present, constant 0, no counter flops.

Decomposition:
- Package adiantamento_pkg:
  - SEL_REGISTRADOR=2'b00, SEL_EX_MEM=2'b01, SEL_MEM_WB=2'b10.
  - REG_ZERO.
  - Slot-record typedef (valido, rd, escreve, le_mem).
- Sub-module comparador_adiantamento: pure combinational per-operand selector logic (operand index plus two slot records -> 2-bit select), instantiated twice (A, B).

Test Plan:
1. reset=0 for 2 cycles with random inputs -> seletor_a=seletor_b=00, bolha=0, contador_bolhas=0.
2. add r3,r1,r2 then sub r4,r3,r5 consecutively -> sub's EX cycle: seletor_a=01, seletor_b=00; no bolha.
3. add r3,... ; or r7,r8,r9 ; and r6,r2,r3 -> and's EX cycle: seletor_b=10, seletor_a=00.
4. add r3 then addi r3 then sub r4,r3,r3 -> seletor_a=seletor_b=01 (newest wins); same sequence targeting r0 -> 00/00.
5. lw r2,0(r1) then add r5,r2,r2 -> bolha=1 for exactly one cycle, EX bubble, then seletor_a=seletor_b=10; contador_bolhas=1 with CONTADOR_BOLHAS_EN.
6. lw hazard with flush=1 in the same cycle -> bolha=0, EX bubble, counter unchanged; repeat with habilita=0 for 3 cycles -> all outputs held.
